apb_completer_mem: RTL and testbench



---
 rtl/axi_to_apb_pkg.sv | 24 ++
 rtl/apb_cpl_regfile.sv | 31 +++
 rtl/apb_completer_mem.sv | 140 ++++++++++++++
 tb/tb_apb_completer_mem.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_to_apb_pkg.sv
// Shared AXI-to-APB definitions: bus widths plus the APB completer's state and
// latched-request types.
package axi_to_apb_pkg;

  localparam int unsigned ADDRESS_WIDTH = 32;
  localparam int unsigned DATA_WIDTH    = 32;
  // Word index before truncation to the memory depth of a given completer.
  localparam int unsigned INDEX_WIDTH   = ADDRESS_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_cpl_state_e;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     write;
    logic                     err;
    logic [INDEX_WIDTH-1:0]   index;
  } apb_cpl_req_t;

endpackage

// File: rtl/apb_cpl_regfile.sv
// Word-wide register file for the APB completer: one synchronous write port,
// one combinational read port, asynchronously cleared on reset.
module apb_cpl_regfile
  import axi_to_apb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_completer_mem.sv
// APB3 completer backed by a word-addressed register file, with a fixed number
// of wait states and PSLVERR on misaligned or out-of-window addresses.
module apb_completer_mem
  import axi_to_apb_pkg::*;
#(
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned              DEPTH       = 16,
  parameter int unsigned              WAIT_STATES = 0
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDRESS_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]    pwdata,
  output logic [DATA_WIDTH-1:0]    prdata,
  output logic                     pready,
  output logic                     pslverr
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  // One extra bit so BASE_ADDR + 4*DEPTH cannot wrap at the top of the map.
  localparam logic [ADDRESS_WIDTH:0] BaseExt  = {1'b0, BASE_ADDR};
  localparam logic [ADDRESS_WIDTH:0] LimitExt = BaseExt + (ADDRESS_WIDTH + 1)'(4 * DEPTH);
  localparam logic [3:0]             WaitLoad = 4'(WAIT_STATES);

  apb_cpl_state_e state_q, state_d;
  apb_cpl_req_t   req_q, req_d;
  logic [3:0]     cnt_q, cnt_d;

  logic                  pready_d, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic                  enter_ready;

  logic                     setup, addr_err, we;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [IdxW-1:0]          raddr;
  logic [DATA_WIDTH-1:0]    rdata;

  assign setup    = psel & ~penable;
  assign offset   = paddr - BASE_ADDR;
  assign addr_err = (paddr[1:0] != 2'b00) || ({1'b0, paddr} < BaseExt) ||
                    ({1'b0, paddr} >= LimitExt);
  // Zero-wait reads must see the word addressed during setup, not the stale latch.
  assign raddr    = (state_q == IDLE) ? offset[IdxW+1:2] : req_q.index[IdxW-1:0];

  apb_cpl_regfile #(
    .DEPTH(DEPTH)
  ) u_regfile (
    .pclk   (pclk),
    .presetn(presetn),
    .we     (we),
    .waddr  (req_q.index[IdxW-1:0]),
    .wdata  (req_q.wdata),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    enter_ready = 1'b0;
    we          = 1'b0;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (setup) begin
          req_d.addr  = paddr;
          req_d.wdata = pwdata;
          req_d.write = pwrite;
          req_d.err   = addr_err;
          req_d.index = offset[ADDRESS_WIDTH-1:2];
          cnt_d       = WaitLoad;
          if (WAIT_STATES == 0) begin
            state_d     = READY;
            enter_ready = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (psel && penable) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d     = READY;
            enter_ready = 1'b1;
          end
        end else begin
          // Deselect or a dropped PENABLE abandons the transfer.
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      READY: begin
        we      = psel && penable && req_q.write && !req_q.err;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enter_ready) begin
      pready_d  = 1'b1;
      pslverr_d = req_d.err;
      prdata_d  = (!req_d.write && !req_d.err) ? rdata : '0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
      prdata  <= prdata_d;
    end
  end

  // The full address and upper index bits are kept for visibility only.
  logic unused_req;
  assign unused_req = ^{req_q.addr, req_q.index, offset[1:0]};

endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: three instances (0, 2 and 3 wait states) on a
// shared APB bus, checked against a simple array model of the memory window.
module tb_apb_completer_mem;

  logic        pclk, presetn, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [2:0]  psel, pready, pslverr;
  logic [31:0] prdata [3];

  int total, bad;
  logic [31:0] model_mem [3][16];

  apb_completer_mem #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .WAIT_STATES(0)) u_dut_ws0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0])
  );
  apb_completer_mem #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .WAIT_STATES(2)) u_dut_ws2 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1])
  );
  apb_completer_mem #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .WAIT_STATES(3)) u_dut_ws3 (
    .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]), .pready(pready[2]),
    .pslverr(pslverr[2])
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  function automatic bit exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h1000) || (a >= 32'h1000 + 4 * 16);
  endfunction

  function automatic int exp_idx(input logic [31:0] a);
    return int'((a - 32'h1000) >> 2);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) model_mem[d][i] = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Full transfer on instance d; called and returns 1 time unit after a rising edge.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic err,
                      output int lat);
    int n;
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    n = 1;
    while (!pready[d] && n < 40) begin
      @(posedge pclk);
      #1;
      n++;
    end
    lat = n;
    rd  = prdata[d];
    err = pslverr[d];
    @(posedge pclk);
    #1;
    psel    = '0;
    penable = 1'b0;
    if (wr && !exp_err(addr)) model_mem[d][exp_idx(addr)] = wd;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    idle(2);
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({pready[d], pslverr[d], prdata[d]} !== 34'd0) begin
        bad++;
        $display("FAIL reset_hold dut%0d: got rdy=%b err=%b data=%h want 0", d, pready[d],
                 pslverr[d], prdata[d]);
      end
    end
    presetn = 1'b1;
    idle(2);
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({pready[d], pslverr[d], prdata[d]} !== 34'd0) begin
        bad++;
        $display("FAIL reset_idle dut%0d: got rdy=%b err=%b data=%h want 0", d, pready[d],
                 pslverr[d], prdata[d]);
      end
    end
    model_clear();
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic        err;
    int          lat;
    xfer(0, 1'b1, 32'h1004, 32'hDEAD_BEEF, rd, err, lat);
    total++;
    if (lat !== 1 || err !== 1'b0) begin
      bad++;
      $display("FAIL basic_write: got lat=%0d err=%b want lat=1 err=0", lat, err);
    end
    xfer(0, 1'b0, 32'h1004, 32'h0, rd, err, lat);
    total++;
    if (lat !== 1 || err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL basic_read: got lat=%0d err=%b data=%h want 1 0 deadbeef", lat, err, rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        err;
    int          lat;
    xfer(2, 1'b0, 32'h1000, 32'h0, rd, err, lat);
    total++;
    if (lat !== 4 || err !== 1'b0 || rd !== 32'h0) begin
      bad++;
      $display("FAIL wait3_read: got lat=%0d err=%b data=%h want 4 0 0", lat, err, rd);
    end
  endtask

  task automatic test_err_decode();
    logic [31:0] rd;
    logic        err;
    int          lat;
    xfer(0, 1'b1, 32'h1002, 32'h1234_5678, rd, err, lat);
    total++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL err_misaligned: got lat=%0d err=%b data=%h want 1 1 0", lat, err, rd);
    end
    xfer(0, 1'b1, 32'h1040, 32'h1234_5678, rd, err, lat);
    total++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL err_range: got lat=%0d err=%b data=%h want 1 1 0", lat, err, rd);
    end
    xfer(0, 1'b0, 32'h1000, 32'h0, rd, err, lat);
    total++;
    if (err !== 1'b0 || rd !== model_mem[0][0]) begin
      bad++;
      $display("FAIL err_untouched: got err=%b data=%h want 0 %h", err, rd, model_mem[0][0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        err;
    int          lat;
    xfer(1, 1'b1, 32'h103C, 32'hA5A5_A5A5, rd, err, lat);
    xfer(1, 1'b0, 32'h103C, 32'h0, rd, err, lat);
    total++;
    if (lat !== 3 || err !== 1'b0 || rd !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL b2b_read: got lat=%0d err=%b data=%h want 3 0 a5a5a5a5", lat, err, rd);
    end
    xfer(1, 1'b0, 32'h0FFC, 32'h0, rd, err, lat);
    total++;
    if (lat !== 3 || err !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL b2b_below: got lat=%0d err=%b data=%h want 3 1 0", lat, err, rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic        err;
    int          lat, seen;
    // Deselect in the first access cycle of a 2-wait-state write.
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1008; pwdata = 32'h1111_1111;
    idle(1);
    psel = '0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (pready[1] || pslverr[1]) seen++;
      idle(1);
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_wait_ready: got %0d ready cycles want 0", seen);
    end
    xfer(1, 1'b0, 32'h1008, 32'h0, rd, err, lat);
    total++;
    if (err !== 1'b0 || rd !== 32'h0) begin
      bad++;
      $display("FAIL abort_wait_mem: got err=%b data=%h want 0 0", err, rd);
    end
    // Deselect while the zero-wait instance is already presenting PREADY.
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1010; pwdata = 32'h2222_2222;
    idle(1);
    psel = '0;
    idle(1);
    total++;
    if (pready[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_ready_clear: got rdy=%b want 0", pready[0]);
    end
    xfer(0, 1'b0, 32'h1010, 32'h0, rd, err, lat);
    total++;
    if (rd !== model_mem[0][4]) begin
      bad++;
      $display("FAIL abort_ready_mem: got data=%h want %h", rd, model_mem[0][4]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        err;
    int          lat;
    xfer(1, 1'b1, 32'h100C, 32'h5, rd, err, lat);
    psel = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h100C;
    idle(1);
    penable = 1'b1;
    idle(1);
    #2;
    presetn = 1'b0; psel = '0; penable = 1'b0;
    #1;
    total++;
    if ({pready[1], pslverr[1], prdata[1]} !== 34'd0) begin
      bad++;
      $display("FAIL reset_in_wait: got rdy=%b err=%b data=%h want 0", pready[1], pslverr[1],
               prdata[1]);
    end
    idle(1);
    presetn = 1'b1;
    model_clear();
    idle(1);
    xfer(1, 1'b0, 32'h100C, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_wait_mem: got data=%h err=%b want 0 0", rd, err);
    end
    // Reset while a read is presenting data must drop it without a clock edge.
    xfer(0, 1'b1, 32'h1014, 32'h77, rd, err, lat);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 32'h1014;
    idle(1);
    penable = 1'b1;
    total++;
    if (pready[0] !== 1'b1 || prdata[0] !== 32'h77) begin
      bad++;
      $display("FAIL reset_pre_ready: got rdy=%b data=%h want 1 00000077", pready[0], prdata[0]);
    end
    #2;
    presetn = 1'b0; psel = '0; penable = 1'b0;
    #1;
    total++;
    if (pready[0] !== 1'b0 || prdata[0] !== 32'h0) begin
      bad++;
      $display("FAIL reset_in_ready: got rdy=%b data=%h want 0 0", pready[0], prdata[0]);
    end
    idle(1);
    presetn = 1'b1;
    model_clear();
    idle(1);
    xfer(0, 1'b0, 32'h1014, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL reset_ready_mem: got data=%h want 0", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd, exp_rd;
    logic        err;
    bit          wr, e_err;
    int          lat, d, r;
    for (int i = 0; i < 80; i++) begin
      d  = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      r  = $urandom_range(0, 9);
      if (r < 7)       addr = 32'h1000 + 4 * $urandom_range(0, 15);
      else if (r == 7) addr = 32'h1000 + $urandom_range(0, 63);
      else if (r == 8) addr = 32'h1040 + 4 * $urandom_range(0, 3);
      else             addr = 32'h0FF0 + 4 * $urandom_range(0, 3);
      e_err  = exp_err(addr);
      exp_rd = (wr || e_err) ? 32'h0 : model_mem[d][exp_idx(addr)];
      xfer(d, wr, addr, wd, rd, err, lat);
      total++;
      if (lat !== ws_of(d) + 1 || err !== e_err || rd !== exp_rd) begin
        bad++;
        $display("FAIL rand_%0d dut%0d %s @%h: got lat=%0d err=%b data=%h want %0d %b %h", i, d,
                 wr ? "wr" : "rd", addr, lat, err, rd, ws_of(d) + 1, e_err, exp_rd);
      end
      if ($urandom_range(0, 1) == 1) idle(1);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    presetn = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    model_clear();
    #1;
    test_reset();
    test_basic();
    test_wait_states();
    test_err_decode();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
